// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher ingress block.
package cipher_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  localparam logic [7:0] CIPHER_SEED_INIT = 8'hCD;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

endpackage

// File: rtl/cipher_ingress_byte_fifo.sv
// 9-bit synchronous FIFO (byte + last flag); first-word fall-through read port.
module byte_fifo
  import cipher_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_word_t  wdata_i,
  input  logic        pop_i,
  output fifo_word_t  rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fifo_word_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cipher_ingress.sv
// Byte-stream feeder for the 8-bit stream cipher: FIFO, per-frame seed loads, tap strobe.
// Define CIPHER_INGRESS_RESEED_EN to reload the seed register at every frame start.
module cipher_ingress
  import cipher_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] SEED_INIT = CIPHER_SEED_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       cfg_seed_valid,
  output logic       cfg_seed_ready,
  input  logic [7:0] cfg_seed,
  input  logic       m_stall,
  output logic       load_seed,
  output logic [7:0] seed_in,
  output logic       encrypt_en,
  output logic [7:0] data_in,
  output logic       tap_valid,
  output logic       tap_last,
  output logic [7:0] frame_cnt
);

  localparam int AW = $clog2(DEPTH);

`ifdef CIPHER_INGRESS_RESEED_EN
  localparam logic RESEED = 1'b1;
`else
  localparam logic RESEED = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  seed_q, seed_d;
  logic        load_q, enc_q, lst_q;
  logic [7:0]  seed_in_q, data_q, frame_q;
  logic [1:0]  tap_vld_q, tap_lst_q;

  logic        push, pop, seed_acc;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_cnt;
  fifo_word_t  wword, rword;

  assign push     = s_valid & ~fifo_full;
  assign wword    = '{last: s_last, data: s_data};
  assign seed_acc = cfg_seed_valid & ~pending_q;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wword),
    .pop_i   (pop),
    .rdata_o (rword),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (fifo_cnt != '0) state_d = (pending_q | RESEED) ? LOAD : RUN;
      LOAD: state_d = RUN;
      RUN: begin
        if (!fifo_empty && !m_stall) begin
          pop = 1'b1;
          if (rword.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A seed accepted during LOAD stays pending so it is applied at the next frame.
  always_comb begin
    seed_d    = seed_acc ? cfg_seed : seed_q;
    pending_d = pending_q;
    if (state_q == LOAD) pending_d = 1'b0;
    if (seed_acc)        pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      seed_q    <= SEED_INIT;
      load_q    <= 1'b0;
      seed_in_q <= '0;
      enc_q     <= 1'b0;
      data_q    <= '0;
      lst_q     <= 1'b0;
      tap_vld_q <= '0;
      tap_lst_q <= '0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      seed_q    <= seed_d;
      load_q    <= (state_d == LOAD);
      if (state_d == LOAD) seed_in_q <= seed_d;
      enc_q     <= pop;
      if (pop) data_q <= rword.data;
      lst_q     <= pop & rword.last;
      tap_vld_q <= {tap_vld_q[0], enc_q};
      tap_lst_q <= {tap_lst_q[0], lst_q};
      if (pop && rword.last) frame_q <= frame_q + 8'd1;
    end
  end

  assign s_ready        = ~fifo_full;
  assign cfg_seed_ready = ~pending_q;
  assign load_seed      = load_q;
  assign seed_in        = seed_in_q;
  assign encrypt_en     = enc_q;
  assign data_in        = data_q;
  assign tap_valid      = tap_vld_q[1];
  assign tap_last       = tap_lst_q[1];
  assign frame_cnt      = frame_q;

endmodule
